// File: rtl/usb_crc_engine.sv
// Bit-serial USB CRC engine (CRC5 tokens / CRC16 data), one polynomial per instance.
// GEN mode hashes TX payload bits, then streams the inverted CRC MSB-first under an
// out_ready stall handshake. CHECK mode hashes payload plus received CRC and compares
// the register against the fixed good-packet residue.
// The LFSR is the MSB-feedback form: with bus-order (LSB-first) input, the appended
// bits come out in the order they must be sent on the bus.
module usb_crc_engine #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = 16'h8005,
    parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESIDUE = 16'h800D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             bit_last,
    output logic             bit_out,
    output logic             bit_out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic [WIDTH-1:0] crc_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_APPEND = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] crc_reg, crc_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mode_reg, mode_next;
    logic             done_reg, done_next;
    logic             ok_reg, ok_next;

    // One LFSR step on bit_in; bit 0 receives fb through POLY[0].
    logic             fb;
    logic [WIDTH-1:0] crc_step;

    assign fb = crc_reg[WIDTH-1] ^ bit_in;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lfsr
            if (gi == 0) begin : g_lsb
                assign crc_step[gi] = fb & POLY[gi];
            end else begin : g_upper
                assign crc_step[gi] = crc_reg[gi-1] ^ (fb & POLY[gi]);
            end
        end
    endgenerate

    // State and datapath registers; rst returns everything to idle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            crc_reg   <= INIT;
            shift_reg <= '0;
            cnt_reg   <= '0;
            mode_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ok_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            crc_reg   <= crc_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            done_reg  <= done_next;
            ok_reg    <= ok_next;
        end
    end

    // Next-state and datapath update; start overrides whatever is in flight.
    always_comb begin
        state_next = state_reg;
        crc_next   = crc_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        done_next  = 1'b0;
        ok_next    = ok_reg;
        if (start) begin
            // Abort silently: no done pulse, previous check result discarded.
            state_next = ST_DATA;
            crc_next   = INIT;
            mode_next  = mode;
            cnt_next   = '0;
            ok_next    = 1'b0;
        end else begin
            case (state_reg)
                ST_DATA: begin
                    if (bit_valid) begin
                        crc_next = crc_step;
                        if (bit_last) begin
                            if (mode_reg) begin
                                state_next = ST_IDLE;
                                done_next  = 1'b1;
                                ok_next    = (crc_step == RESIDUE);
                            end else begin
                                // Capture the inverted CRC including the final bit.
                                state_next = ST_APPEND;
                                shift_next = ~crc_step;
                                cnt_next   = '0;
                            end
                        end
                    end
                end
                ST_APPEND: begin
                    if (out_ready) begin
                        shift_next = {shift_reg[WIDTH-2:0], 1'b0};
                        if (cnt_reg == LAST_CNT) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs derived from the current state.
    always_comb begin
        bit_out       = 1'b0;
        bit_out_valid = 1'b0;
        busy          = (state_reg != ST_IDLE);
        if (state_reg == ST_APPEND) begin
            bit_out       = shift_reg[WIDTH-1];
            bit_out_valid = 1'b1;
        end
    end

    assign done    = done_reg;
    assign crc_ok  = ok_reg;
    assign crc_out = crc_reg;

endmodule

// File: tb/tb_usb_crc_engine.sv
// Directed bench for usb_crc_engine: a CRC5 and a CRC16 instance share the input
// stimulus; each vector selects which instance's outputs are checked.
module tb_usb_crc_engine;

    logic clk = 1'b0;
    logic rst, start, mode, bit_in, bit_valid, bit_last, out_ready;

    logic        bo5, bov5, busy5, done5, ok5;
    logic [4:0]  crc5;
    logic        bo16, bov16, busy16, done16, ok16;
    logic [15:0] crc16;

    always #5 clk = ~clk;

    usb_crc_engine #(
        .WIDTH(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C)
    ) u_crc5 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_last(bit_last), .bit_out(bo5),
        .bit_out_valid(bov5), .out_ready(out_ready), .busy(busy5),
        .done(done5), .crc_ok(ok5), .crc_out(crc5)
    );

    usb_crc_engine #(
        .WIDTH(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUE(16'h800D)
    ) u_crc16 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_last(bit_last), .bit_out(bo16),
        .bit_out_valid(bov16), .out_ready(out_ready), .busy(busy16),
        .done(done16), .crc_ok(ok16), .crc_out(crc16)
    );

    // Output view of the instance under test.
    logic        sel;
    logic        o_bit, o_bv, o_busy, o_done, o_ok;
    logic [15:0] o_crc;

    always_comb begin
        if (sel) begin
            o_bit = bo16; o_bv = bov16; o_busy = busy16;
            o_done = done16; o_ok = ok16; o_crc = crc16;
        end else begin
            o_bit = bo5; o_bv = bov5; o_busy = busy5;
            o_done = done5; o_ok = ok5; o_crc = {11'd0, crc5};
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_op(input logic m);
        start = 1'b1; mode = m; bit_valid = 1'b0; bit_last = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            bit_in = p[i]; bit_valid = 1'b1; bit_last = (i == n - 1);
            tick();
        end
        bit_valid = 1'b0; bit_last = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        sel;       // 0: CRC5 instance, 1: CRC16 instance
        logic        mode;      // 0: GEN, 1: CHECK
        int          nbits;
        logic [31:0] payload;   // bit i sent i-th (bus order)
        logic [31:0] gaps;      // bit i set: one idle cycle before payload bit i
        logic [15:0] exp_crc;
        logic        exp_ok;
        logic [15:0] exp_app;   // append sequence, first bit in [W-1]
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        int          w;
        int          early_done;
        logic [15:0] got;
        w = v.sel ? 16 : 5;
        sel = v.sel;
        out_ready = 1'b1;
        start_op(v.mode);
        chk({v.name, ".busy_start"}, o_busy, 1'b1);
        chk({v.name, ".crc_init"}, o_crc, v.sel ? 16'hFFFF : 16'h001F);
        early_done = 0;
        for (int i = 0; i < v.nbits; i++) begin
            if (v.gaps[i]) begin
                // bit_last without bit_valid must be ignored.
                bit_valid = 1'b0;
                bit_in    = 1'($urandom_range(0, 1));
                bit_last  = 1'($urandom_range(0, 1));
                tick();
                if (o_done) early_done++;
            end
            bit_in = v.payload[i]; bit_valid = 1'b1; bit_last = (i == v.nbits - 1);
            tick();
            if (i != v.nbits - 1 && o_done) early_done++;
        end
        bit_valid = 1'b0; bit_last = 1'b0;
        chk({v.name, ".early_done"}, early_done, 0);
        chk({v.name, ".crc"}, o_crc, v.exp_crc);
        if (v.mode) begin
            chk({v.name, ".done"}, o_done, 1'b1);
            chk({v.name, ".ok"}, o_ok, v.exp_ok);
            chk({v.name, ".busy_end"}, o_busy, 1'b0);
            tick();
            chk({v.name, ".done_pulse"}, o_done, 1'b0);
            chk({v.name, ".ok_hold"}, o_ok, v.exp_ok);
        end else begin
            chk({v.name, ".app_valid"}, o_bv, 1'b1);
            chk({v.name, ".app_nodone"}, o_done, 1'b0);
            got = '0;
            for (int k = 0; k < w; k++) begin
                got[w-1-k] = o_bit;
                if (!o_bv || o_done) early_done++;
                tick();
            end
            chk({v.name, ".app_flow"}, early_done, 0);
            chk({v.name, ".append"}, got, v.exp_app);
            chk({v.name, ".done"}, o_done, 1'b1);
            chk({v.name, ".bv_at_done"}, o_bv, 1'b0);
            chk({v.name, ".busy_end"}, o_busy, 1'b0);
            tick();
            chk({v.name, ".done_pulse"}, o_done, 1'b0);
            chk({v.name, ".crc_frozen"}, o_crc, v.exp_crc);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic        ready;
        logic [15:0] got;
        int          bad;

        // Hand-computed vectors. CRC5 of 11 zero bits leaves 0x17; its inverse 0x08
        // goes out 0,1,0,0,0 (token CRC 0x02 in bus order).
        vecs[0] = '{"gen5_zero11",  1'b0, 1'b0, 11, 32'h0,    32'h0,    16'h0017, 1'b0, 16'h0008};
        vecs[1] = '{"gen5_gaps",    1'b0, 1'b0, 11, 32'h0,    32'h04A5, 16'h0017, 1'b0, 16'h0008};
        vecs[2] = '{"chk5_good",    1'b0, 1'b1, 16, 32'h1000, 32'h0,    16'h000C, 1'b1, 16'h0};
        vecs[3] = '{"chk5_bad",     1'b0, 1'b1, 16, 32'h0,    32'h0,    16'h0001, 1'b0, 16'h0};
        vecs[4] = '{"chk16_data0",  1'b1, 1'b1, 16, 32'h0,    32'h0,    16'h800D, 1'b1, 16'h0};
        vecs[5] = '{"chk16_gaps",   1'b1, 1'b1, 16, 32'h0,    32'h9121, 16'h800D, 1'b1, 16'h0};
        vecs[6] = '{"chk16_bit7",   1'b1, 1'b1, 16, 32'h0080, 32'h0,    16'h060E, 1'b0, 16'h0};
        vecs[7] = '{"gen16_one",    1'b1, 1'b0, 1,  32'h1,    32'h0,    16'hFFFE, 1'b0, 16'h0001};
        vecs[8] = '{"gen16_zero",   1'b1, 1'b0, 1,  32'h0,    32'h0,    16'h7FFB, 1'b0, 16'h8004};

        rst = 1'b1; start = 1'b0; mode = 1'b0; bit_in = 1'b0;
        bit_valid = 1'b0; bit_last = 1'b0; out_ready = 1'b1; sel = 1'b0;
        @(negedge clk);
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("reset%0d.crc", s), o_crc, s[0] ? 16'hFFFF : 16'h001F);
            chk($sformatf("reset%0d.outs", s), {o_bit, o_bv, o_busy, o_done, o_ok}, 5'b0);
        end
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
            $display("vector %0s done, checks=%0d errors=%0d", vecs[i].name, checks, errors);
        end

        // Stall mid-append on the CRC5 instance: out_ready low for 3 cycles while
        // the second append bit (1) is presented.
        sel = 1'b0;
        start_op(1'b0);
        feed(32'h0, 11);
        got = '0; k = 0; bad = 0;
        for (int c = 0; c < 8; c++) begin
            ready = !(c >= 1 && c <= 3);
            out_ready = ready;
            if (!o_bv || o_done) bad++;
            if (ready) begin
                got[4-k] = o_bit;
                k++;
            end else begin
                chk($sformatf("stall.held%0d", c), o_bit, 1'b1);
            end
            tick();
        end
        out_ready = 1'b1;
        chk("stall.flow", bad, 0);
        chk("stall.append", got, 16'h0008);
        chk("stall.done", o_done, 1'b1);
        chk("stall.bv_at_done", o_bv, 1'b0);
        $display("sequence stall done, checks=%0d errors=%0d", checks, errors);

        // bit_valid in IDLE must not move the register.
        bit_valid = 1'b1; bit_in = 1'b1; bit_last = 1'b1;
        tick(); tick(); tick();
        bit_valid = 1'b0; bit_last = 1'b0;
        chk("idle.crc", o_crc, 16'h0017);
        chk("idle.busy", o_busy, 1'b0);
        chk("idle.done", o_done, 1'b0);
        $display("sequence idle done, checks=%0d errors=%0d", checks, errors);

        // Abort by start during APPEND, then rst during DATA.
        start_op(1'b1);
        feed(32'h1000, 16);
        chk("abort.ok_before", o_ok, 1'b1);
        start_op(1'b0);
        chk("abort.ok_cleared", o_ok, 1'b0);
        feed(32'h0, 11);
        tick(); tick();
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        chk("abort.done", o_done, 1'b0);
        chk("abort.bv", o_bv, 1'b0);
        chk("abort.busy", o_busy, 1'b1);
        chk("abort.crc_init", o_crc, 16'h001F);
        bit_valid = 1'b1; bit_last = 1'b0;
        bit_in = 1'b1; tick();
        bit_in = 1'b0; tick();
        bit_in = 1'b1; tick();
        bit_valid = 1'b0;
        chk("abort.crc_mid", o_crc, 16'h0012);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst.crc", o_crc, 16'h001F);
        chk("rst.outs", {o_bit, o_bv, o_busy, o_done, o_ok}, 5'b0);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (o_done || o_busy) bad++;
        end
        chk("rst.quiet", bad, 0);
        $display("sequence abort done, checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
